// File: rtl/ps_ureg_file_if.sv
// PS-group ureg bus between the ureg decoder (master) and the program-sequencer
// register bank (slave): read/write address, strobes, stack qualifiers and status flags.
interface ps_ureg_file_if #(
    parameter int DATA_W = 16
);
    logic [4:0]        ps_rd_add;
    logic [DATA_W-1:0] ps_rd_data;
    logic [4:0]        ps_wrt_add;
    logic              ps_wrt_en;
    logic [DATA_W-1:0] ps_wrt_data;
    logic              ps_stk_push;
    logic              ps_stk_pop;
    logic              ps_lcntr_dec;
    logic              ps_stk_full;
    logic              ps_stk_empty;
    logic              ps_stk_ovf;
    logic              ps_lcntr_zero;

    modport master (
        output ps_rd_add, ps_wrt_add, ps_wrt_en, ps_wrt_data,
               ps_stk_push, ps_stk_pop, ps_lcntr_dec,
        input  ps_rd_data, ps_stk_full, ps_stk_empty, ps_stk_ovf, ps_lcntr_zero
    );

    modport slave (
        input  ps_rd_add, ps_wrt_add, ps_wrt_en, ps_wrt_data,
               ps_stk_push, ps_stk_pop, ps_lcntr_dec,
        output ps_rd_data, ps_stk_full, ps_stk_empty, ps_stk_ovf, ps_lcntr_zero
    );
endinterface

// File: rtl/ps_ureg_file.sv
// Program-sequencer universal-register bank: MODE1, ASTAT, LCNTR, STKY and a PC stack.
// Reads are combinational from pre-edge state; writes, push, pop and LCNTR decrement commit on clk.
module ps_ureg_file #(
    parameter int DATA_W    = 16,
    parameter int STK_DEPTH = 8
) (
    input logic           clk,
    input logic           reset,
    ps_ureg_file_if.slave ps
);
    localparam int SP_W  = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = $clog2(STK_DEPTH);

    localparam logic [4:0] A_MODE1  = 5'h00;
    localparam logic [4:0] A_ASTAT  = 5'h01;
    localparam logic [4:0] A_PCSTK  = 5'h04;
    localparam logic [4:0] A_PCSTKP = 5'h05;
    localparam logic [4:0] A_LCNTR  = 5'h06;
    localparam logic [4:0] A_STKY   = 5'h07;

    logic [DATA_W-1:0] mode1_q, mode1_d;
    logic [DATA_W-1:0] astat_q, astat_d;
    logic [DATA_W-1:0] lcntr_q, lcntr_d;
    logic [1:0]        stky_q,  stky_d;
    logic [SP_W-1:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0] stk_q [STK_DEPTH];
    logic [DATA_W-1:0] stk_d [STK_DEPTH];

    logic              empty, full, push, pop, wr_top;
    logic [SP_W-1:0]   cnt_m1;
    logic [IDX_W-1:0]  top_idx, push_idx;
    logic [DATA_W-1:0] top_val, rd_data;
    logic [1:0]        stky_set;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == SP_W'(STK_DEPTH));
    assign cnt_m1   = cnt_q - 1'b1;
    assign top_idx  = cnt_m1[IDX_W-1:0];
    assign push_idx = cnt_q[IDX_W-1:0];
    assign top_val  = empty ? '0 : stk_q[top_idx];

    assign push   = ps.ps_wrt_en && (ps.ps_wrt_add == A_PCSTK) && ps.ps_stk_push;
    assign wr_top = ps.ps_wrt_en && (ps.ps_wrt_add == A_PCSTK) && !ps.ps_stk_push;
    assign pop    = (ps.ps_rd_add == A_PCSTK) && ps.ps_stk_pop;

    always_comb begin
        rd_data = '0;
        case (ps.ps_rd_add)
            A_MODE1:  rd_data = mode1_q;
            A_ASTAT:  rd_data = astat_q;
            A_PCSTK:  rd_data = top_val;
            A_PCSTKP: rd_data = DATA_W'(cnt_q);
            A_LCNTR:  rd_data = lcntr_q;
            A_STKY:   rd_data = {{(DATA_W-2){1'b0}}, stky_q};
            default:  rd_data = '0;
        endcase
    end

    assign ps.ps_rd_data    = rd_data;
    assign ps.ps_stk_full   = full;
    assign ps.ps_stk_empty  = empty;
    assign ps.ps_stk_ovf    = stky_q[0];
    assign ps.ps_lcntr_zero = (lcntr_q == '0);

    always_comb begin
        stk_d    = stk_q;
        cnt_d    = cnt_q;
        stky_set = 2'b00;
        if (push && pop) begin
            // Simultaneous push/pop replaces the top; on an empty stack the pop underflows first.
            if (empty) begin
                stky_set[1] = 1'b1;
                stk_d[0]    = ps.ps_wrt_data;
                cnt_d       = SP_W'(1);
            end else begin
                stk_d[top_idx] = ps.ps_wrt_data;
            end
        end else if (push) begin
            if (full) begin
                stky_set[0] = 1'b1;
            end else begin
                stk_d[push_idx] = ps.ps_wrt_data;
                cnt_d           = cnt_q + 1'b1;
            end
        end else begin
            if (wr_top && !empty) stk_d[top_idx] = ps.ps_wrt_data;
            if (pop) begin
                if (empty) stky_set[1] = 1'b1;
                else       cnt_d = cnt_m1;
            end
        end
    end

    always_comb begin
        mode1_d = (ps.ps_wrt_en && ps.ps_wrt_add == A_MODE1) ? ps.ps_wrt_data : mode1_q;
        astat_d = (ps.ps_wrt_en && ps.ps_wrt_add == A_ASTAT) ? ps.ps_wrt_data : astat_q;
        stky_d  = ((ps.ps_wrt_en && ps.ps_wrt_add == A_STKY) ? ps.ps_wrt_data[1:0] : stky_q)
                  | stky_set;
        // Software write wins over the loop-end decrement; decrement saturates at zero.
        lcntr_d = lcntr_q;
        if (ps.ps_wrt_en && ps.ps_wrt_add == A_LCNTR) lcntr_d = ps.ps_wrt_data;
        else if (ps.ps_lcntr_dec && lcntr_q != '0)     lcntr_d = lcntr_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode1_q <= '0;
            astat_q <= '0;
            lcntr_q <= '0;
            stky_q  <= '0;
            cnt_q   <= '0;
            stk_q   <= '{default: '0};
        end else begin
            mode1_q <= mode1_d;
            astat_q <= astat_d;
            lcntr_q <= lcntr_d;
            stky_q  <= stky_d;
            cnt_q   <= cnt_d;
            stk_q   <= stk_d;
        end
    end
endmodule

// File: tb/tb_ps_ureg_file.sv
// Directed bench for ps_ureg_file: stimulus queues expected observations per cycle,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_ps_ureg_file;
    localparam int K_RD = 0, K_FULL = 1, K_EMPTY = 2, K_OVF = 3, K_LZ = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    ps_ureg_file_if #(.DATA_W(16)) bus ();

    ps_ureg_file #(.DATA_W(16), .STK_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .ps    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [15:0] act;
            e = q.pop_front();
            case (e.kind)
                K_RD:    act = bus.ps_rd_data;
                K_FULL:  act = {15'd0, bus.ps_stk_full};
                K_EMPTY: act = {15'd0, bus.ps_stk_empty};
                K_OVF:   act = {15'd0, bus.ps_stk_ovf};
                default: act = {15'd0, bus.ps_lcntr_zero};
            endcase
            total++;
            if (e.cyc != cyc || act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h (cyc %0d, expected at %0d)",
                         e.name, act, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic idle();
        bus.ps_rd_add    = 5'h00;
        bus.ps_wrt_add   = 5'h00;
        bus.ps_wrt_en    = 1'b0;
        bus.ps_wrt_data  = 16'h0;
        bus.ps_stk_push  = 1'b0;
        bus.ps_stk_pop   = 1'b0;
        bus.ps_lcntr_dec = 1'b0;
        reset            = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_v(input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] v, input string name);
        bus.ps_rd_add = a;
        expect_v(K_RD, v, name);
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic psh);
        bus.ps_wrt_en   = 1'b1;
        bus.ps_wrt_add  = a;
        bus.ps_wrt_data = d;
        bus.ps_stk_push = psh;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1; idle();
        reset = 1'b1;
        tick();

        // Reset state
        rd(5'h05, 16'h0, "rst_pcstkp");
        expect_v(K_EMPTY, 16'h1, "rst_empty");
        expect_v(K_FULL,  16'h0, "rst_full");
        expect_v(K_OVF,   16'h0, "rst_ovf");
        expect_v(K_LZ,    16'h1, "rst_lzero");
        tick();

        // Reset mid-sequence after three pushes
        for (int i = 1; i <= 3; i++) begin wr(5'h04, 16'(i), 1'b1); tick(); end
        rd(5'h05, 16'h3, "pre_rst_pcstkp");
        wr(5'h04, 16'h4, 1'b1);
        reset = 1'b1;
        tick();
        rd(5'h05, 16'h0, "midrst_pcstkp");
        expect_v(K_EMPTY, 16'h1, "midrst_empty");
        tick();
        rd(5'h04, 16'h0, "midrst_pcstk");
        tick();
        rd(5'h07, 16'h0, "midrst_stky");
        tick();

        // Fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            wr(5'h04, 16'h0100 + 16'(i), 1'b1);
            expect_v(K_FULL, 16'h0, "fill_notfull");
            tick();
        end
        rd(5'h05, 16'h8, "full_pcstkp");
        expect_v(K_FULL, 16'h1, "full_flag");
        tick();
        wr(5'h04, 16'hBEEF, 1'b1);
        expect_v(K_OVF, 16'h0, "pre_ovf");
        tick();
        rd(5'h04, 16'h0108, "ovf_top");
        expect_v(K_OVF, 16'h1, "ovf_flag");
        tick();
        rd(5'h05, 16'h8, "ovf_pcstkp");
        tick();

        // Drain with pops, then underflow
        for (int i = 8; i >= 1; i--) begin
            rd(5'h04, 16'h0100 + 16'(i), "pop_data");
            bus.ps_stk_pop = 1'b1;
            tick();
        end
        expect_v(K_EMPTY, 16'h1, "drained_empty");
        tick();
        rd(5'h04, 16'h0, "underflow_data");
        bus.ps_stk_pop = 1'b1;
        tick();
        rd(5'h07, 16'h3, "stky_both");
        tick();

        // Clearing STKY clears ovf
        wr(5'h07, 16'h0, 1'b0);
        expect_v(K_OVF, 16'h1, "ovf_before_clr");
        tick();
        expect_v(K_OVF, 16'h0, "ovf_cleared");
        rd(5'h07, 16'h0, "stky_cleared");
        tick();

        // Push and pop in the same cycle with count=2
        wr(5'h04, 16'h0011, 1'b1); tick();
        wr(5'h04, 16'h0022, 1'b1); tick();
        wr(5'h04, 16'h0033, 1'b1);
        rd(5'h04, 16'h0022, "pp_old_top");
        bus.ps_stk_pop = 1'b1;
        tick();
        rd(5'h05, 16'h2, "pp_pcstkp");
        tick();
        rd(5'h04, 16'h0033, "pp_new_top");
        tick();

        // Plain write to PCSTK overwrites top
        wr(5'h04, 16'h0044, 1'b0); tick();
        rd(5'h04, 16'h0044, "ovw_top");
        tick();
        rd(5'h05, 16'h2, "ovw_pcstkp");
        tick();

        // Push & pop on empty: underflow, then push lands; set beats same-cycle STKY clear is n/a here
        rd(5'h04, 16'h0044, "drain1"); bus.ps_stk_pop = 1'b1; tick();
        rd(5'h04, 16'h0011, "drain2"); bus.ps_stk_pop = 1'b1; tick();
        wr(5'h04, 16'h0055, 1'b1);
        rd(5'h04, 16'h0, "ppe_data");
        bus.ps_stk_pop = 1'b1;
        tick();
        rd(5'h05, 16'h1, "ppe_pcstkp");
        tick();
        rd(5'h04, 16'h0055, "ppe_top");
        tick();
        rd(5'h07, 16'h2, "ppe_stky");
        tick();

        // Hardware set wins over same-cycle software clear
        wr(5'h04, 16'h0066, 1'b1);
        bus.ps_wrt_add = 5'h04;
        tick();
        wr(5'h07, 16'h0, 1'b0);
        bus.ps_rd_add = 5'h04; bus.ps_stk_pop = 1'b1;
        tick();
        rd(5'h05, 16'h1, "setwin_pcstkp");
        tick();
        rd(5'h07, 16'h0, "setwin_stky_clear_pop_ok");
        tick();
        rd(5'h04, 16'h0055, "setwin_top");
        bus.ps_stk_pop = 1'b1;
        tick();
        wr(5'h07, 16'h0, 1'b0);
        bus.ps_rd_add = 5'h04; bus.ps_stk_pop = 1'b1;
        tick();
        rd(5'h07, 16'h2, "setwin_stky");
        tick();

        // LCNTR write, decrement, saturation, write priority
        wr(5'h06, 16'h2, 1'b0); tick();
        rd(5'h06, 16'h2, "lc_wr");
        expect_v(K_LZ, 16'h0, "lc_nz");
        bus.ps_lcntr_dec = 1'b1;
        tick();
        rd(5'h06, 16'h1, "lc_dec1");
        bus.ps_lcntr_dec = 1'b1;
        tick();
        rd(5'h06, 16'h0, "lc_dec2");
        expect_v(K_LZ, 16'h1, "lc_zero");
        bus.ps_lcntr_dec = 1'b1;
        tick();
        rd(5'h06, 16'h0, "lc_sat");
        wr(5'h06, 16'h5, 1'b0);
        bus.ps_lcntr_dec = 1'b1;
        tick();
        rd(5'h06, 16'h5, "lc_wr_prio");
        tick();

        // MODE1 no-bypass, ASTAT, read-only and unmapped addresses
        wr(5'h00, 16'hA5A5, 1'b0);
        rd(5'h00, 16'h0, "mode1_old");
        tick();
        rd(5'h00, 16'hA5A5, "mode1_new");
        wr(5'h01, 16'h1234, 1'b0);
        tick();
        rd(5'h01, 16'h1234, "astat");
        wr(5'h05, 16'h0007, 1'b0);
        tick();
        rd(5'h05, 16'h0, "pcstkp_ro");
        wr(5'h02, 16'hFFFF, 1'b0);
        tick();
        rd(5'h02, 16'h0, "unmapped");
        tick();
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
